md_unit: RTL

Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair. It sits in the EX stage beside the ALU and consumes the `Start`/`MD_ctr` signals produced by the control unit. The unit is generalised in operand width and in per-operation latency, and adds a signed multiply-subtract mode. Its `Busy` output, ORed with `Start`, drives the hazard unit's stall for any HI/LO-touching instruction.

---
 rtl/md_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair.
// Multi-cycle ops latch their operands at issue and commit to HI/LO when the down-counter expires.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MD_ctr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;
  localparam logic [2:0] OpMadd  = 3'b110;
  localparam logic [2:0] OpMsub  = 3'b111;

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

  // Full-precision products; low 2*WIDTH bits of the sign-extended product give the signed result.
  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u, acc;
  assign a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign a_zx   = {{WIDTH{1'b0}}, a_q};
  assign b_zx   = {{WIDTH{1'b0}}, b_q};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;
  assign acc    = {hi_q, lo_q};

  // Signed division via magnitudes; MIN / -1 naturally yields quotient MIN, remainder 0.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, mag_q, mag_r, sq, sr, uq, ur;
  assign a_neg  = a_q[WIDTH-1];
  assign b_neg  = b_q[WIDTH-1];
  assign b_zero = (b_q == '0);
  assign a_mag  = a_neg ? -a_q : a_q;
  assign b_mag  = b_neg ? -b_q : b_q;
  assign mag_q  = b_zero ? '0 : a_mag / b_mag;
  assign mag_r  = b_zero ? '0 : a_mag % b_mag;
  assign sq     = (a_neg ^ b_neg) ? -mag_q : mag_q;
  assign sr     = a_neg ? -mag_r : mag_r;
  assign uq     = b_zero ? '0 : a_q / b_q;
  assign ur     = b_zero ? '0 : a_q % b_q;

  logic [2*WIDTH-1:0] result;
  always_comb begin
    result = acc;
    unique case (op_q)
      OpMult:  result = prod_s;
      OpMultu: result = prod_u;
      OpMadd:  result = acc + prod_s;
      OpMsub:  result = acc - prod_s;
      OpDiv:   result = b_zero ? {a_q, {WIDTH{1'b1}}} : {sr, sq};
      OpDivu:  result = b_zero ? {a_q, {WIDTH{1'b1}}} : {ur, uq};
      default: result = acc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          if (MD_ctr == OpMthi) begin
            hi_d = A;
          end else if (MD_ctr == OpMtlo) begin
            lo_d = A;
          end else begin
            a_d     = A;
            b_d     = B;
            op_d    = MD_ctr;
            cnt_d   = (MD_ctr == OpDiv || MD_ctr == OpDivu) ? CntW'(DIV_CYCLES)
                                                            : CntW'(MULT_CYCLES);
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // Start is ignored here; the pipeline stalls on Busy.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          {hi_d, lo_d} = result;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == StRun);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
